output_port_arbiter: RTL and testbench

Per-output-port arbiter and forwarder of the 4-port switch, one instance per egress port, sitting directly downstream of the four ingress FIFOs. It inspects each FIFO's head header without popping it and picks, round-robin, among non-empty FIFOs whose head packet is destined to this port. It pops exactly one word from the winner and presents it on a valid/ready egress interface. Only one instance ever reads a given FIFO head, because a head packet matches exactly one PORT_ID.

---
 rtl/output_port_arbiter.sv | 132 +++++++++++++
 tb/tb_output_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Egress arbiter for one switch port: round-robin picks one ingress FIFO whose
// head packet targets PORT_ID, pops one word and forwards it on valid/ready.

// Per-ingress request decode: FIFO has data and its head is bound for us.
module opa_req_lane #(
   parameter logic [1:0] PORT_ID = 2'd0
) (
   input  logic       empty_i,
   input  logic [1:0] dst_i,
   output logic       req_o
);
   assign req_o = !empty_i && (dst_i == PORT_ID);
endmodule

module output_port_arbiter #(
   parameter int unsigned PORT_ID    = 0,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [3:0]                          fifo_empty_i,
   input  logic [3:0][DATA_WIDTH/2-1:0]        hdr_i,
   input  logic [3:0][DATA_WIDTH-1:0]          fifo_data_i,
   output logic [3:0]                          rd_en_o,
   output logic [DATA_WIDTH-1:0]               out_data,
   output logic [1:0]                          out_src,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy,
   output logic [15:0]                         pkt_count
);
   localparam logic [1:0] PID = PORT_ID[1:0];

   typedef enum logic [1:0] {IDLE, READ, LATCH, SEND} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              grant_q, grant_d;
   logic [1:0]              winner_q, winner_d;
   logic [1:0]              last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [1:0]              out_src_q, out_src_d;
   logic [15:0]             pkt_count_q, pkt_count_d;
   logic [3:0]              req;
   logic [1:0]              pick;
   logic                    hdr_unused;

   // Only the destination field of each header matters here.
   assign hdr_unused = ^hdr_i;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      opa_req_lane #(.PORT_ID(PID)) u_lane (
         .empty_i (fifo_empty_i[g]),
         .dst_i   (hdr_i[g][7:6]),
         .req_o   (req[g])
      );
   end

   // Round-robin pick: scan far-to-near so the requester closest after
   // last_grant overwrites the others.
   always_comb begin
      logic [1:0] idx;
      pick = last_grant_q;
      idx  = last_grant_q;
      for (int k = 4; k >= 1; k--) begin
         idx = last_grant_q + 2'(k);
         if (req[idx]) pick = idx;
      end
   end

   // Next-state and datapath updates; requests only looked at in IDLE so a
   // transfer in flight is immune to header changes.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      winner_d     = winner_q;
      last_grant_d = last_grant_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      pkt_count_d  = pkt_count_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d      = 4'b0001 << pick;
               winner_d     = pick;
               last_grant_d = pick;
               state_d      = READ;
            end
         end
         READ:  state_d = LATCH;
         LATCH: begin
            out_data_d = fifo_data_i[winner_q];
            out_src_d  = winner_q;
            state_d    = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any word already popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         winner_q     <= '0;
         last_grant_q <= 2'd3;
         out_data_q   <= '0;
         out_src_q    <= '0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         winner_q     <= winner_d;
         last_grant_q <= last_grant_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign rd_en_o   = (state_q == READ) ? grant_q : 4'b0000;
   assign out_valid = (state_q == SEND);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter (PORT_ID = 2) with a registered-output FIFO
// model and a scoreboard of expected forwarded words.
module tb_output_port_arbiter;
   localparam int DW = 32;
   localparam int HW = DW / 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [3:0]           fifo_empty_i;
   logic [3:0][HW-1:0]   hdr_i;
   logic [3:0][DW-1:0]   fifo_data_i;
   logic [3:0]           rd_en_o;
   logic [DW-1:0]        out_data;
   logic [1:0]           out_src;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;
   logic [15:0]          pkt_count;

   output_port_arbiter #(.PORT_ID(2), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty_i), .hdr_i(hdr_i),
      .fifo_data_i(fifo_data_i), .rd_en_o(rd_en_o), .out_data(out_data),
      .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // FIFO model: contents/write pointers owned by the stimulus, read side here.
   logic [DW-1:0] mem [4][64];
   logic [5:0]    wr_cnt [4];
   logic [5:0]    rd_cnt [4];
   logic          tb_init;

   for (genvar g = 0; g < 4; g++) begin : g_fifo
      assign fifo_empty_i[g] = (rd_cnt[g] == wr_cnt[g]);
      assign hdr_i[g]        = {8'h00, mem[g][rd_cnt[g]][7:0]};
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (tb_init) begin
            rd_cnt[i]      <= '0;
            fifo_data_i[i] <= '0;
         end else if (rd_en_o[i]) begin
            fifo_data_i[i] <= mem[i][rd_cnt[i]];
            rd_cnt[i]      <= rd_cnt[i] + 6'd1;
         end
      end
   end

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    src;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   seq_n   = 0;

   function automatic logic [DW-1:0] mk(input int f, input int s, input logic [7:0] h);
      logic [31:0] fv, sv;
      fv = f;
      sv = s;
      return {4'hD, fv[3:0], sv[15:0], h};
   endfunction

   task automatic push(input int f, input logic [7:0] h, input bit expect_out);
      logic [DW-1:0] w;
      exp_t e;
      w = mk(f, seq_n, h);
      seq_n++;
      mem[f][wr_cnt[f]] = w;
      wr_cnt[f] = wr_cnt[f] + 6'd1;
      if (expect_out) begin
         e.data = w;
         e.src  = 2'(f);
         exp_q.push_back(e);
      end
   endtask

   // One cycle: called just after a falling edge; scores a handshake that will
   // complete on the coming rising edge, then moves to the next falling edge.
   task automatic tick();
      exp_t e;
      if (out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got data=%h src=%0d, required no output", out_data, out_src);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_src !== e.src) begin
               n_fail++;
               $display("FAIL sb_word: got data=%h src=%0d, required data=%h src=%0d",
                        out_data, out_src, e.data, e.src);
            end
         end
      end
      n_tests++;
      if (!$onehot0(rd_en_o)) begin
         n_fail++;
         $display("FAIL rd_en_onehot: got %b, required one-hot or zero", rd_en_o);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name, input int max_cyc);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < max_cyc) begin
         tick();
         c++;
      end
      n_tests++;
      if (exp_q.size() != 0 || busy) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d words pending busy=%b, required 0 pending busy=0",
                  name, exp_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({rd_en_o, out_valid, out_data, out_src, busy, pkt_count} !== {4'b0, 1'b0, 32'h0, 2'd0, 1'b0, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got rd=%b v=%b d=%h s=%0d busy=%b cnt=%0d, required all zero",
                  rd_en_o, out_valid, out_data, out_src, busy, pkt_count);
      end
   endtask

   task automatic test_single();
      logic [DW-1:0] w;
      out_ready = 1'b1;
      w = mk(1, seq_n, 8'h90);
      push(1, 8'h90, 1'b1);
      tick();
      n_tests++;
      if (rd_en_o !== 4'b0010 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_read: got rd=%b busy=%b, required rd=0010 busy=1", rd_en_o, busy);
      end
      tick();
      n_tests++;
      if (rd_en_o !== 4'b0000 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_latch: got rd=%b v=%b, required rd=0000 v=0", rd_en_o, out_valid);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== w || out_src !== 2'd1) begin
         n_fail++;
         $display("FAIL single_send: got v=%b d=%h s=%0d, required v=1 d=%h s=1", out_valid, out_data, out_src, w);
      end
      tick();
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_count !== 16'd1) begin
         n_fail++;
         $display("FAIL single_done: got busy=%b v=%b cnt=%0d, required busy=0 v=0 cnt=1", busy, out_valid, pkt_count);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      do_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int f = 0; f < 4; f++)
            push(f, 8'h80 | 8'(f << 4), 1'b1);
      drain("rr", 200);
      n_tests++;
      if (pkt_count !== 16'd12) begin
         n_fail++;
         $display("FAIL rr_count: got %0d, required 12", pkt_count);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] w3;
      int c;
      out_ready = 1'b0;
      w3 = mk(3, seq_n, 8'hB0);
      push(3, 8'hB0, 1'b1);
      c = 0;
      while (!out_valid && c < 10) begin
         tick();
         c++;
      end
      push(0, 8'h80, 1'b1);
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if ({out_valid, out_src, out_data, rd_en_o} !== {1'b1, 2'd3, w3, 4'b0000}) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b s=%0d d=%h rd=%b, required v=1 s=3 d=%h rd=0000",
                     out_valid, out_src, out_data, rd_en_o, w3);
         end
         tick();
      end
      out_ready = 1'b1;
      drain("bp", 40);
      n_tests++;
      if (pkt_count !== 16'd14) begin
         n_fail++;
         $display("FAIL bp_count: got %0d, required 14", pkt_count);
      end
   endtask

   task automatic test_reset_latch();
      out_ready = 1'b1;
      push(2, 8'hA0, 1'b0);
      tick();
      tick();
      n_tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || rd_en_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL rl_latch_state: got busy=%b v=%b rd=%b, required busy=1 v=0 rd=0000", busy, out_valid, rd_en_o);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({rd_en_o, out_valid, out_data, out_src, busy, pkt_count} !== {4'b0, 1'b0, 32'h0, 2'd0, 1'b0, 16'h0}) begin
         n_fail++;
         $display("FAIL rl_outputs: got rd=%b v=%b d=%h s=%0d busy=%b cnt=%0d, required all zero",
                  rd_en_o, out_valid, out_data, out_src, busy, pkt_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Restored last_grant=3 puts FIFO0 ahead of FIFO3.
      push(0, 8'h80, 1'b1);
      push(3, 8'hB0, 1'b0);
      exp_q.push_back('{data: mk(3, seq_n - 1, 8'hB0), src: 2'd3});
      drain("rl", 40);
      n_tests++;
      if (pkt_count !== 16'd2) begin
         n_fail++;
         $display("FAIL rl_count: got %0d, required 2", pkt_count);
      end
   endtask

   task automatic test_saturation();
      force dut.pkt_count_q = 16'hFFFE;
      tick();
      release dut.pkt_count_q;
      n_tests++;
      if (pkt_count !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL sat_preload: got %h, required fffe", pkt_count);
      end
      out_ready = 1'b1;
      push(1, 8'h90, 1'b1);
      push(1, 8'h90, 1'b1);
      drain("sat", 40);
      n_tests++;
      if (pkt_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_count: got %h, required ffff", pkt_count);
      end
   endtask

   task automatic test_filter();
      out_ready = 1'b1;
      push(0, 8'h40, 1'b0);
      push(3, 8'hB0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if (rd_en_o !== 4'b0000 && rd_en_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL filter_rd: got %b, required 0000 or 1000", rd_en_o);
         end
         tick();
      end
      n_tests++;
      if (exp_q.size() != 0 || fifo_empty_i[0] !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL filter_end: got pending=%0d fifo0_empty=%b busy=%b, required 0 0 0",
                  exp_q.size(), fifo_empty_i[0], busy);
      end
   endtask

   initial begin
      tb_init   = 1'b1;
      rst_n     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr_cnt[i] = '0;
      @(posedge clk);
      @(negedge clk);
      tb_init = 1'b0;
      test_reset();
      rst_n = 1'b1;
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_latch();
      test_saturation();
      test_filter();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
